calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Multi-cycle sequencer for the calculator datapath. Replaces the free-running PC++ with an FSM:
//  FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. Owns the PC.
//  Strobes the instruction fetch, ULA, memory op2 port and register-bank write, one step at a time.
//  Waits on the memory ready handshake and stops cleanly on a halt op.
// PARAMETERS
//  PC_W          32  PC width; the PC wraps modulo 2^PC_W
//  RESET_PC      0   PC value loaded by reset
//  MEM_WAIT_MAX  15  max cycles to wait for _mem_ready before entering ERROR (4-bit wait counter)
// PORTS
//  _clock        in   1     system clock, all state on posedge
//  _reset_n      in   1     asynchronous, active-low reset
//  _start        in   1     level; leaves IDLE
//  _mem_ready    in   1     memory completed the current fetch/op2 access this cycle
//  _mem_control  in   2     from decoder: 00 none, 01 halt, 10 load, 11 store
//  _write_enable in   1     from decoder: instruction writes the register bank
//  _pc           out  PC_W  address for instruction fetch
//  _fetch_en     out  1     instruction read request
//  _ir_load      out  1     1-cycle pulse: latch the instruction word
//  _ula_go       out  1     1-cycle pulse: ULA evaluates
//  _op2_en       out  1     memory data-port request
//  _op2_rw       out  1     0 read, 1 write; valid while _op2_en=1
//  _reg_we       out  1     1-cycle register-bank write pulse
//  _busy         out  1     state is not IDLE, HALT or ERROR
//  _halted       out  1     sticky: halt executed
//  _error        out  1     sticky: memory wait timeout
//  _retired      out  32    instructions completed, wraps at 2^32
// BEHAVIOUR
//  Reset (async, any state, mid-access included):
//   - state=IDLE, _pc=RESET_PC, _retired=0, wait counter=0.
//   - All strobes, _busy, _halted and _error = 0 immediately.
//  All outputs are Moore outputs decoded from registered state.
//  IDLE:
//   - _start=1 -> FETCH. Otherwise hold.
//  FETCH:
//   - _fetch_en=1.
//   - _mem_ready=1 -> _ir_load=1 in that same cycle; next state DECODE.
//   - Otherwise increment the wait counter.
//  DECODE (1 cycle):
//   - Register _mem_control and _write_enable into the op class; it is held until retire.
//   - Class 01 -> HALT, no retire, PC not advanced. Any other class -> EXEC.
//  EXEC (1 cycle):
//   - _ula_go=1.
//   - Class 10/11 -> MEM. Otherwise: write=1 -> WB; write=0 -> retire.
//  MEM:
//   - _op2_en=1; _op2_rw=1 for store (11), 0 for load (10).
//   - _mem_ready=1 -> load goes to WB, store retires.
//   - Otherwise the wait counter runs.
//  WB (1 cycle):
//   - _reg_we=1, then retire.
//  Retire:
//   - Next state FETCH; _pc <= _pc+1 (all-ones wraps to 0); _retired <= _retired+1.
//   - Both update on the same edge.
//  Wait counter:
//   - Cleared on every state change.
//   - Reaching MEM_WAIT_MAX in FETCH or MEM without _mem_ready -> ERROR.
//   - _mem_ready on the limit cycle wins: normal transition, no error.
//  HALT / ERROR:
//   - Terminal until reset; all strobes 0; _start ignored.
//   - HALT sets _halted=1; ERROR sets _error=1.
//  _mem_ready outside FETCH and MEM is ignored.
//  _start dropping while busy has no effect.
//  Never more than one of _ir_load, _ula_go, _reg_we active per cycle.
// STRUCTURE
//  Package calc_pkg:
//   - State encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR (3 bits).
//   - Mem-control encodings MC_NONE, MC_HALT, MC_LOAD, MC_STORE.
//  Sub-module calc_wait_timer:
//   - 4-bit counter with clear and enable inputs; outputs expired (count==MEM_WAIT_MAX).
//  Top level: FSM next-state logic, PC register, op-class register, retire counter.
// TESTING
//  1. Reset, _start=1, _mem_ready tied 1, ALU op (00, write=1)
//     -> states F,D,E,W; _reg_we in cycle 4; _pc 0->1; _retired=1.
//  2. Load (10, write=1), _mem_ready low for 3 MEM cycles
//     -> _op2_en=1 and _op2_rw=0 for 4 cycles, then one _reg_we; total 8 cycles per instruction.
//  3. Store (11) -> _op2_rw=1 in MEM, no _reg_we, PC+1.
//  4. Halt (01) after 2 ALU ops -> _halted=1, _retired=2, _pc=2.
//     _start/_mem_ready toggling afterwards changes nothing.
//  5. _mem_ready held 0 in FETCH -> _error=1 after 15 cycles, _fetch_en drops.
//     Repeat with ready on cycle 15 -> DECODE, no error.
//  6. RESET_PC=32'hFFFFFFFF, one ALU op retires -> _pc=0.
//     Assert _reset_n=0 mid-MEM -> _op2_en falls asynchronously, state IDLE.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types for the calculator sequencer: FSM state
//                encoding, memory-control opcodes and the latched op class.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // Memory-control field from the decoder
    localparam logic [1:0] MC_NONE  = 2'b00;
    localparam logic [1:0] MC_HALT  = 2'b01;
    localparam logic [1:0] MC_LOAD  = 2'b10;
    localparam logic [1:0] MC_STORE = 2'b11;

    // Instruction class captured in DECODE and held until retire
    typedef struct packed {
        logic [1:0] mem_control;
        logic       write;
    } op_class_t;

    // Loads and stores both need the memory data port (upper bit set)
    function automatic logic is_mem_op(input logic [1:0] mc);
        return mc[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_wait_timer
//  Description : 4-bit memory-wait counter with synchronous clear and count
//                enable; flags expiry when the count reaches MEM_WAIT_MAX.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [3:0] count;

    // Count stalled cycles; saturate at the limit so a late clear never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (enable && !expired) begin
            count <= count + 4'd1;
        end
    end

    assign expired = (count == 4'(MEM_WAIT_MAX));

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
//                calculator datapath. Owns the PC, strobes each datapath stage
//                in turn, waits on memory ready and stops on halt or timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              MEM_WAIT_MAX = 15
) (
    input  logic            _clock,
    input  logic            _reset_n,
    input  logic            _start,
    input  logic            _mem_ready,
    input  logic [1:0]      _mem_control,
    input  logic            _write_enable,
    output logic [PC_W-1:0] _pc,
    output logic            _fetch_en,
    output logic            _ir_load,
    output logic            _ula_go,
    output logic            _op2_en,
    output logic            _op2_rw,
    output logic            _reg_we,
    output logic            _busy,
    output logic            _halted,
    output logic            _error,
    output logic [31:0]     _retired
);

    state_t    state;
    state_t    next_state;
    op_class_t op_class;
    logic      retire;
    logic      wait_expired;
    logic      wait_clear;
    logic      wait_enable;

    // State register
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) state <= ST_IDLE;
        else           state <= next_state;
    end

    // Next-state decode; retire marks the edge that completes an instruction
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (_start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (_mem_ready)        next_state = ST_DECODE;
                else if (wait_expired) next_state = ST_ERROR;
            end
            ST_DECODE: begin
                if (_mem_control == MC_HALT) next_state = ST_HALT;
                else                         next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem_op(op_class.mem_control)) begin
                    next_state = ST_MEM;
                end else if (op_class.write) begin
                    next_state = ST_WB;
                end else begin
                    next_state = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            ST_MEM: begin
                if (_mem_ready) begin
                    if (op_class.mem_control == MC_STORE) begin
                        next_state = ST_FETCH;
                        retire     = 1'b1;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (wait_expired) begin
                    next_state = ST_ERROR;
                end
            end
            ST_WB: begin
                next_state = ST_FETCH;
                retire     = 1'b1;
            end
            default: next_state = state;   // HALT and ERROR are terminal
        endcase
    end

    // Capture the decoder fields once per instruction so EXEC/MEM see a stable class
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n)                op_class <= '0;
        else if (state == ST_DECODE)  op_class <= '{mem_control: _mem_control, write: _write_enable};
    end

    // PC and retire counter advance together on the retiring edge
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            _pc      <= RESET_PC;
            _retired <= 32'd0;
        end else if (retire) begin
            _pc      <= _pc + {{(PC_W-1){1'b0}}, 1'b1};
            _retired <= _retired + 32'd1;
        end
    end

    // Wait counter restarts on every state change and only runs while stalled on memory
    assign wait_clear  = (next_state != state);
    assign wait_enable = ((state == ST_FETCH) || (state == ST_MEM)) && !_mem_ready;

    calc_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (_clock),
        .rst_n   (_reset_n),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (wait_expired)
    );

    // Strobes are state decodes; ir_load additionally qualifies on the fetch handshake
    assign _fetch_en = (state == ST_FETCH);
    assign _ir_load  = (state == ST_FETCH) && _mem_ready;
    assign _ula_go   = (state == ST_EXEC);
    assign _op2_en   = (state == ST_MEM);
    assign _op2_rw   = (state == ST_MEM) && (op_class.mem_control == MC_STORE);
    assign _reg_we   = (state == ST_WB);
    assign _busy     = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERROR);
    assign _halted   = (state == ST_HALT);
    assign _error    = (state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_sequencer
//  Description : Self-checking bench for calc_sequencer. Each instruction is
//                expanded into its expected per-cycle strobe pattern from the
//                instruction class and chosen memory latencies; PC/retire
//                counts are tracked as plain integers.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam logic [31:0] B_RESET_PC = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  mem_control = MC_NONE;
    logic        write_enable = 1'b0;

    logic [31:0] a_pc, a_retired, b_pc, b_retired;
    logic a_fetch_en, a_ir_load, a_ula_go, a_op2_en, a_op2_rw, a_reg_we, a_busy, a_halted, a_error;
    logic b_fetch_en, b_ir_load, b_ula_go, b_op2_en, b_op2_rw, b_reg_we, b_busy, b_halted, b_error;

    calc_sequencer #(.PC_W(32), .RESET_PC(32'd0), .MEM_WAIT_MAX(15)) dut_a (
        ._clock(clk), ._reset_n(rst_n), ._start(start), ._mem_ready(mem_ready),
        ._mem_control(mem_control), ._write_enable(write_enable),
        ._pc(a_pc), ._fetch_en(a_fetch_en), ._ir_load(a_ir_load), ._ula_go(a_ula_go),
        ._op2_en(a_op2_en), ._op2_rw(a_op2_rw), ._reg_we(a_reg_we), ._busy(a_busy),
        ._halted(a_halted), ._error(a_error), ._retired(a_retired)
    );

    calc_sequencer #(.PC_W(32), .RESET_PC(B_RESET_PC), .MEM_WAIT_MAX(15)) dut_b (
        ._clock(clk), ._reset_n(rst_n), ._start(start), ._mem_ready(mem_ready),
        ._mem_control(mem_control), ._write_enable(write_enable),
        ._pc(b_pc), ._fetch_en(b_fetch_en), ._ir_load(b_ir_load), ._ula_go(b_ula_go),
        ._op2_en(b_op2_en), ._op2_rw(b_op2_rw), ._reg_we(b_reg_we), ._busy(b_busy),
        ._halted(b_halted), ._error(b_error), ._retired(b_retired)
    );

    // Observed vector: {fetch_en, ir_load, ula_go, op2_en, op2_rw, reg_we, busy, halted, error}
    logic [8:0] obs;
    assign obs = {a_fetch_en, a_ir_load, a_ula_go, a_op2_en, a_op2_rw, a_reg_we, a_busy, a_halted, a_error};

    localparam logic [8:0] V_OFF    = 9'b000000000;
    localparam logic [8:0] V_DECODE = 9'b000000100;
    localparam logic [8:0] V_EXEC   = 9'b001000100;
    localparam logic [8:0] V_WB     = 9'b000001100;
    localparam logic [8:0] V_HALT   = 9'b000000010;
    localparam logic [8:0] V_ERROR  = 9'b000000001;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_pc = 32'd0;
    logic [31:0] model_retired = 32'd0;

    function automatic logic [8:0] v_fetch(input logic rdy);
        return {1'b1, rdy, 7'b0000100};
    endfunction

    function automatic logic [8:0] v_mem(input logic store);
        return {3'b000, 1'b1, store, 4'b0100};
    endfunction

    task automatic check_vec(input string tag, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check32({tag, "_pc"}, a_pc, model_pc);
        check32({tag, "_pc_b"}, b_pc, model_pc + B_RESET_PC);
        check32({tag, "_retired"}, a_retired, model_retired);
    endtask

    // One clock cycle: drive ready after the falling edge, then sample
    task automatic cycle(input logic rdy, input logic [8:0] exp, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        #1;
        check_vec(tag, exp);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
        #1;
        model_pc = 32'd0; model_retired = 32'd0;
        check_vec("reset_outputs", V_OFF);
        check_counters("reset");
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; mem_ready = rbit();
        #1;
        check_vec("idle", V_OFF);
    endtask

    // Expected behaviour of one instruction given its fetch and memory latencies
    task automatic run_instr(input logic [1:0] mc, input logic we, input int fd, input int md);
        for (int i = 0; i <= fd; i++) begin
            @(negedge clk);
            mem_control = mc; write_enable = we; mem_ready = (i == fd);
            #1;
            if (i == 0) check_counters("instr_start");
            check_vec("fetch", v_fetch(i == fd));
        end
        cycle(rbit(), V_DECODE, "decode");
        if (mc == MC_HALT) return;
        cycle(rbit(), V_EXEC, "exec");
        if (mc == MC_LOAD || mc == MC_STORE) begin
            for (int j = 0; j <= md; j++) cycle(j == md, v_mem(mc == MC_STORE), "mem");
        end
        if (mc == MC_LOAD || (mc == MC_NONE && we)) cycle(rbit(), V_WB, "wb");
        model_pc      = model_pc + 32'd1;
        model_retired = model_retired + 32'd1;
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_counters(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] mc;
        int fd, md;

        // ALU op with write, then load with a 3-cycle memory stall, then store
        do_reset();
        run_instr(MC_NONE, 1'b1, 0, 0);
        check_model("after_alu");             // dut_b wraps from all-ones to 0 here
        run_instr(MC_LOAD, 1'b1, 0, 3);
        run_instr(MC_STORE, 1'b0, 1, 2);
        run_instr(MC_NONE, 1'b0, 2, 0);

        // Random instruction mix with random latencies, occasionally on the limit cycle
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(2, 0))
                0:       mc = MC_NONE;
                1:       mc = MC_LOAD;
                default: mc = MC_STORE;
            endcase
            fd = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(3, 0));
            md = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(3, 0));
            run_instr(mc, rbit(), fd, md);
        end
        check_model("after_random");

        // Halt after two ALU ops; afterwards inputs are ignored
        do_reset();
        run_instr(MC_NONE, 1'b1, 0, 0);
        run_instr(MC_NONE, 1'b0, 0, 0);
        run_instr(MC_HALT, 1'b0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = rbit(); mem_ready = rbit();
            mem_control = 2'($urandom_range(3, 0)); write_enable = rbit();
            #1;
            check_vec("halted", V_HALT);
        end
        check_counters("halted");

        // Fetch timeout: 15 counted stall cycles plus the limit cycle, then ERROR
        do_reset();
        for (int i = 0; i <= 15; i++) cycle(1'b0, v_fetch(1'b0), "fetch_wait");
        cycle(1'b1, V_ERROR, "fetch_timeout");
        cycle(rbit(), V_ERROR, "error_sticky");

        // Ready on the limit cycle wins
        do_reset();
        run_instr(MC_NONE, 1'b1, 15, 0);
        check_model("limit_ready");

        // Memory-phase timeout
        do_reset();
        run_instr(MC_NONE, 1'b0, 0, 0);
        mem_control = MC_LOAD; write_enable = 1'b1;
        cycle(1'b1, v_fetch(1'b1), "mem_to_fetch");
        cycle(1'b0, V_DECODE, "mem_to_decode");
        cycle(1'b0, V_EXEC, "mem_to_exec");
        for (int j = 0; j <= 15; j++) cycle(1'b0, v_mem(1'b0), "mem_wait");
        cycle(1'b0, V_ERROR, "mem_timeout");

        // Asynchronous reset in the middle of a store access
        do_reset();
        run_instr(MC_NONE, 1'b1, 0, 0);
        mem_control = MC_STORE; write_enable = 1'b0;
        cycle(1'b1, v_fetch(1'b1), "ar_fetch");
        cycle(1'b0, V_DECODE, "ar_decode");
        cycle(1'b0, V_EXEC, "ar_exec");
        cycle(1'b0, v_mem(1'b1), "ar_mem");
        rst_n = 1'b0;
        #1;
        model_pc = 32'd0; model_retired = 32'd0;
        check_vec("async_reset_outputs", V_OFF);
        check_counters("async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
